// File: rtl/elephant_swapmv_seq.sv
// Multi-cycle SWAPMOVE engine for Elephant pstep2: single step (op_x/op_y) or
// chained steps 0..L, one step per cycle, with a valid/ready result buffer.

module elephant_swapmv_lane (
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [2:0]  k_i,
    output logic [31:0] x_o,
    output logic [31:0] y_o,
    output logic [31:0] xr_o
);
    logic [4:0]  s;
    logic [31:0] m;
    logic [31:0] t;

    always_comb begin
        s = 5'd0;
        m = 32'h0;
        case (k_i)
            3'd0: begin s = 5'd8;  m = 32'h000000FF; end
            3'd1: begin s = 5'd16; m = 32'h000000FF; end
            3'd2: begin s = 5'd24; m = 32'h000000FF; end
            3'd3: begin s = 5'd8;  m = 32'h0000FF00; end
            3'd4: begin s = 5'd24; m = 32'h000000FF; end
            3'd5: begin s = 5'd16; m = 32'h0000FF00; end
            3'd6: begin s = 5'd8;  m = 32'h00FF0000; end
            default: begin s = 5'd0; m = 32'h0; end
        endcase
        t   = ((x_i >> s) ^ y_i) & m;
        x_o = x_i ^ (t << s);
        y_o = y_i ^ t;
        // Single op_x for the upper steps returns x rotated back into place
        case (k_i)
            3'd4:    xr_o = {x_o[23:0], x_o[31:24]};
            3'd5:    xr_o = {x_o[15:0], x_o[31:16]};
            3'd6:    xr_o = {x_o[7:0],  x_o[31:8]};
            default: xr_o = x_o;
        endcase
    end
endmodule

module elephant_swapmv_seq #(
    parameter int LANES = 1
) (
    input  logic                  g_clk,
    input  logic                  g_rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   rs1,
    input  logic [32*LANES-1:0]   rs2,
    input  logic [2:0]            imm,
    input  logic                  op_x,
    input  logic                  op_y,
    input  logic                  op_chain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   rd,
    output logic [32*LANES-1:0]   rd_y
);
    localparam int XLEN = 32 * LANES;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        lst_q, lst_d;
    logic [XLEN-1:0]   wx_q, wx_d, wy_q, wy_d;
    logic [XLEN-1:0]   rd_q, rd_d, rdy_q, rdy_d;

    logic                    run;
    logic                    acc;
    logic [2:0]              step_k;
    logic [2:0]              chain_l;
    logic [LANES-1:0][31:0]  sx_in, sy_in, sx, sy, sxr;

    // One shared step datapath: fed by operands on accept, by the work regs in RUN
    assign run     = (state_q == S_RUN);
    assign step_k  = run ? (cnt_q + 3'd1) : (op_chain ? 3'd0 : imm);
    assign sx_in   = run ? wx_q : rs1;
    assign sy_in   = run ? wy_q : rs2;
    assign chain_l = (imm == 3'd7) ? 3'd6 : imm;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        elephant_swapmv_lane u_lane (
            .x_i  (sx_in[g]),
            .y_i  (sy_in[g]),
            .k_i  (step_k),
            .x_o  (sx[g]),
            .y_o  (sy[g]),
            .xr_o (sxr[g])
        );
    end

    assign in_ready  = ~g_rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign out_valid = (state_q == S_DONE);
    assign acc       = in_valid & in_ready & ~flush;
    assign rd        = rd_q;
    assign rd_y      = rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lst_d   = lst_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        rd_d    = rd_q;
        rdy_d   = rdy_q;

        case (state_q)
            S_RUN: begin
                wx_d  = sx;
                wy_d  = sy;
                cnt_d = step_k;
                if (step_k == lst_q) begin
                    rd_d    = sx;
                    rdy_d   = sy;
                    state_d = S_DONE;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: ;
        endcase

        // A new request overrides the DONE->IDLE drain for zero-bubble issue
        if (acc) begin
            cnt_d = 3'd0;
            if (op_chain) begin
                lst_d = chain_l;
                if (chain_l == 3'd0) begin
                    rd_d    = sx;
                    rdy_d   = sy;
                    state_d = S_DONE;
                end else begin
                    wx_d    = sx;
                    wy_d    = sy;
                    state_d = S_RUN;
                end
            end else begin
                rdy_d   = '0;
                state_d = S_DONE;
                if (imm == 3'd7 || !(op_x || op_y)) rd_d = '0;
                else if (op_y)                      rd_d = sy;
                else                                rd_d = sxr;
            end
        end

        // Kill keeps the last delivered result visible
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            rd_d    = rd_q;
            rdy_d   = rdy_q;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            lst_q   <= 3'd0;
            wx_q    <= '0;
            wy_q    <= '0;
            rd_q    <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lst_q   <= lst_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_elephant_swapmv_seq.sv
// Bench for elephant_swapmv_seq: RV32 and RV64 instances driven in lockstep,
// table vectors, handshake/flush/reset sequences and a random model check.

module tb_elephant_swapmv_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, ox, oy, oc, out_ready;
    logic [2:0]  imm;
    logic [31:0] rs1, rs2, rd, rdy;
    logic [63:0] rs1w, rs2w, rdw, rdyw;
    logic        in_ready, out_valid, in_ready2, out_valid2;

    elephant_swapmv_seq #(.LANES(1)) u_dut (
        .g_clk(clk), .g_rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .op_x(ox), .op_y(oy), .op_chain(oc),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .rd_y(rdy));

    elephant_swapmv_seq #(.LANES(2)) u_dut2 (
        .g_clk(clk), .g_rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .rs1(rs1w), .rs2(rs2w), .imm(imm), .op_x(ox), .op_y(oy), .op_chain(oc),
        .out_valid(out_valid2), .out_ready(out_ready), .rd(rdw), .rd_y(rdyw));

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: pstep2 rules evaluated directly on one 32-bit lane, returns {rd, rd_y}
    function automatic logic [63:0] mdl(input logic [31:0] x0, input logic [31:0] y0,
                                        input logic [2:0] im, input logic x, input logic y,
                                        input logic c);
        int          sh [7];
        logic [31:0] mk [7];
        logic [31:0] xv, yv, t;
        int          last, rot;
        sh = '{8, 16, 24, 8, 24, 16, 8};
        mk = '{32'hFF, 32'hFF, 32'hFF, 32'hFF00, 32'hFF, 32'hFF00, 32'hFF0000};
        xv = x0;
        yv = y0;
        if (c) begin
            last = (im > 3'd6) ? 6 : int'(im);
            for (int k = 0; k <= last; k++) begin
                t  = ((xv >> sh[k]) ^ yv) & mk[k];
                xv = xv ^ (t << sh[k]);
                yv = yv ^ t;
            end
            return {xv, yv};
        end
        if (!(x || y) || im == 3'd7) return 64'h0;
        t  = ((xv >> sh[im]) ^ yv) & mk[im];
        xv = xv ^ (t << sh[im]);
        yv = yv ^ t;
        if (y) return {yv, 32'h0};
        rot = (im >= 3'd4) ? (int'(im) - 3) * 8 : 0;
        if (rot != 0) xv = (xv << rot) | (xv >> (32 - rot));
        return {xv, 32'h0};
    endfunction

    task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [63:0] aw,
                           input logic [63:0] bw, input logic [2:0] im, input logic x,
                           input logic y, input logic c);
        rs1 = a; rs2 = b; rs1w = aw; rs2w = bw; imm = im; ox = x; oy = y; oc = c;
    endtask

    // Issue from IDLE, wait bounded for the result, optionally stall the consumer, then drain
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] aw,
                          input logic [63:0] bw, input logic [2:0] im, input logic x,
                          input logic y, input logic c, input int stall,
                          output logic [31:0] r, output logic [31:0] ry,
                          output logic [63:0] rw, output logic [63:0] ryw, output int lat);
        set_req(a, b, aw, bw, im, x, y, c);
        in_valid = 1'b1;
        chk("in_ready_at_issue", {in_ready, in_ready2}, 2'b11);
        tick();
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rs1w = {$urandom, $urandom}; rs2w = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 16) begin
            tick();
            lat++;
        end
        chk("out_valid2_lockstep", out_valid2, 1'b1);
        r = rd; ry = rdy; rw = rdw; ryw = rdyw;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_hold", {rd, rdy, out_valid, in_ready}, {r, ry, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  im;
        logic        x, y, c;
        logic [31:0] er, ery;
        int          lat;
    } vec_t;

    vec_t        tv [11];
    logic [31:0] r, ry, hold;
    logic [63:0] rw, ryw, e, ew;
    int          lat, el;
    logic        seen;

    initial begin
        tv[0]  = '{32'h12345678, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h12340078, 32'h0, 1};
        tv[1]  = '{32'h12345678, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h00000056, 32'h0, 1};
        tv[2]  = '{32'h12345678, 32'h0, 3'd4, 1'b1, 1'b0, 1'b0, 32'h34567800, 32'h0, 1};
        tv[3]  = '{32'h12345678, 32'h0, 3'd4, 1'b0, 1'b1, 1'b0, 32'h00000012, 32'h0, 1};
        tv[4]  = '{32'h12345678, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1};
        tv[5]  = '{32'h12345678, 32'h0, 3'd7, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1};
        tv[6]  = '{32'h12345678, 32'h0, 3'd1, 1'b0, 1'b0, 1'b1, 32'h12560078, 32'h00000034, 2};
        tv[7]  = '{32'h12345678, 32'h0, 3'd1, 1'b1, 1'b1, 1'b1, 32'h12560078, 32'h00000034, 2};
        tv[8]  = '{32'h12345678, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h12340078, 32'h00000056, 1};
        tv[9]  = '{32'h12345678, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h00000056, 32'h0, 1};
        tv[10] = '{32'hDEADBEEF, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(32'h0, 32'h0, 64'h0, 64'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("in_ready_in_reset", {in_ready, in_ready2}, 2'b00);
        rst = 1'b0;
        #1;
        chk("reset_state", {in_ready, out_valid, in_ready2, out_valid2}, 4'b1010);
        chk("reset_rd", {rd, rdy}, 64'h0);
        chk("reset_rdw", rdw | rdyw, 64'h0);

        // Table vectors; the wide DUT sees the same lane twice to expose cross-lane leakage
        for (int i = 0; i < 11; i++) begin
            run_op(tv[i].a, tv[i].b, {tv[i].a, tv[i].a}, {tv[i].b, tv[i].b}, tv[i].im,
                   tv[i].x, tv[i].y, tv[i].c, i % 3, r, ry, rw, ryw, lat);
            chk($sformatf("vec%0d_rd", i), r, tv[i].er);
            chk($sformatf("vec%0d_rdy", i), ry, tv[i].ery);
            chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_rdw", i), rw, {tv[i].er, tv[i].er});
            chk($sformatf("vec%0d_rdyw", i), ryw, {tv[i].ery, tv[i].ery});
        end

        // Chain: in_ready low while running
        set_req(32'h12345678, 32'h0, 64'h0, 64'h0, 3'd1, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("chain_run", {out_valid, in_ready}, 2'b00);
        tick();
        chk("chain_done", {out_valid, rd, rdy}, {1'b1, 32'h12560078, 32'h00000034});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure then zero-bubble reissue
        set_req(32'h12345678, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_first", {out_valid, rd}, {1'b1, 32'h12340078});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {out_valid, in_ready, rd}, {1'b1, 1'b0, 32'h12340078});
        end
        set_req(32'h12345678, 32'h0, 64'h0, 64'h0, 3'd4, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("bp_ready_with_out_ready", in_ready, 1'b1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_next_result", {out_valid, rd}, {1'b1, 32'h00000012});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_keeps_rd", {out_valid, in_ready, rd}, {1'b0, 1'b1, 32'h00000012});

        // DONE with simultaneous chain accept goes straight into RUN
        run_op(32'h0, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0, 0, r, ry, rw, ryw, lat);
        set_req(32'hCAFEF00D, 32'h13579BDF, 64'h0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        set_req(32'h89ABCDEF, 32'h01234567, 64'h0, 64'h0, 3'd2, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_run", {out_valid, in_ready}, 2'b00);
        tick();
        chk("b2b_run2", out_valid, 1'b0);
        tick();
        e = mdl(32'h89ABCDEF, 32'h01234567, 3'd2, 1'b0, 1'b0, 1'b1);
        chk("b2b_result", {out_valid, rd, rdy}, {1'b1, e});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        hold = rd;

        // Flush in 3rd cycle of a 7-step chain
        set_req(32'hA5A51234, 32'h5A5A9876, 64'h0, 64'h0, 3'd6, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {out_valid, in_ready}, 2'b01);
        chk("flush_keeps_rd", rd, hold);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("flush_no_valid", seen, 1'b0);

        // Accept attempted during flush is dropped
        set_req(32'hFFFFFFFF, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_drop_accept", {out_valid, rd}, {1'b0, hold});
        run_op(32'h12345678, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1, 1'b0, 1'b0, 0, r, ry, rw, ryw, lat);
        chk("after_flush_op", {r, lat}, {32'h12340078, 32'd1});

        // Reset in 3rd cycle of a 7-step chain
        set_req(32'hA5A51234, 32'h5A5A9876, 64'h1, 64'h2, 3'd6, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_idle", {out_valid, in_ready}, 2'b01);
        chk("rst_rd_zero", {rd, rdy}, 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid | (|rd) | (|rdy);
        end
        chk("rst_quiet", seen, 1'b0);
        run_op(32'h12345678, 32'h0, 64'h0, 64'h0, 3'd4, 1'b1, 1'b0, 1'b0, 0, r, ry, rw, ryw, lat);
        chk("after_rst_op", r, 32'h34567800);

        // Random ops against the model on both widths
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b;
            logic [63:0] aw, bw;
            logic [2:0]  im, ops;
            a = $urandom; b = $urandom; aw = {$urandom, $urandom}; bw = {$urandom, $urandom};
            im = 3'($urandom_range(0, 7));
            ops = 3'($urandom_range(0, 7));
            run_op(a, b, aw, bw, im, ops[0], ops[1], ops[2], $urandom_range(0, 2),
                   r, ry, rw, ryw, lat);
            e  = mdl(a, b, im, ops[0], ops[1], ops[2]);
            el = ops[2] ? ((im > 3'd6) ? 7 : int'(im) + 1) : 1;
            chk($sformatf("rnd%0d_rd", n), {r, ry}, e);
            chk($sformatf("rnd%0d_lat", n), lat, el);
            e  = mdl(aw[63:32], bw[63:32], im, ops[0], ops[1], ops[2]);
            ew = mdl(aw[31:0], bw[31:0], im, ops[0], ops[1], ops[2]);
            chk($sformatf("rnd%0d_rdw", n), {rw, ryw}, {e[63:32], ew[63:32], e[31:0], ew[31:0]});
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
